// File: rtl/spi_pkg.sv
// Shared definitions for the SPI serf: frame width, serf state encoding and
// the shift-in helper used by both the per-bit shift and the end-of-frame shift.
package spi_pkg;

    localparam int SPI_FRAME_W = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } serf_state_e;

    // Shift one bit into the LSB end of a frame-wide register (MSB leaves first).
    function automatic logic [SPI_FRAME_W-1:0] shift_in(
        input logic [SPI_FRAME_W-1:0] cur,
        input logic                   bit_in
    );
        return {cur[SPI_FRAME_W-2:0], bit_in};
    endfunction

endpackage

// File: rtl/spi_serf_if.sv
// SPI bus bundle between a monarch and the serf. The master modport is the
// monarch side (drives select, clock and MOSI); the slave modport is the serf.
interface spi_serf_if;

    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (
        output SS_n,
        output SCLK,
        output MOSI,
        input  MISO
    );

    modport slave (
        input  SS_n,
        input  SCLK,
        input  MOSI,
        output MISO
    );

endinterface

// File: rtl/spi_edge_sync.sv
// Three-flop synchronizer for an asynchronous level. Stages one and two form
// the metastability guard; stage three is a delayed copy so that rising and
// falling edges of the synchronized level can be detected.
module spi_edge_sync
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int STAGES = 3;

    logic [STAGES-1:0] ff_reg;
    logic [STAGES-1:0] ff_next;

    // Each stage takes the previous one; stage zero takes the raw input.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign ff_next[gi] = async_in;
            end else begin : g_chain
                assign ff_next[gi] = ff_reg[gi-1];
            end
        end
    endgenerate

    // Advance the synchronizer chain; reset parks every stage at the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_reg <= {STAGES{RST_VAL}};
        end else begin
            ff_reg <= ff_next;
        end
    end

    assign level = ff_reg[1];
    assign rise  = ff_reg[1] & ~ff_reg[2];
    assign fall  = ~ff_reg[1] & ff_reg[2];

endmodule

// File: rtl/spi_serf.sv
// SPI serf: receives a 16-bit frame MSB first on MOSI (sampled on SCLK rise,
// shifted on SCLK fall) while returning the shift register on MISO.
// Optional build macro SPI_SERF_MISO_TRI_EN: MISO floats while the
// synchronized SS_n is high.
module spi_serf
    import spi_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    spi_serf_if.slave              bus,
    input  logic                   wrt,
    input  logic [SPI_FRAME_W-1:0] tx_data,
    output logic [SPI_FRAME_W-1:0] rx_data,
    output logic                   rdy,
    input  logic                   clr_rdy
);

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_SHIFT = SHIFT;

    logic ss_level, ss_rise, ss_fall;
    logic sclk_level, sclk_rise, sclk_fall;

    logic mosi_ff1_reg, mosi_ff2_reg;

    logic [0:0]             state_reg, state_next;
    logic [SPI_FRAME_W-1:0] shft_reg, shft_next;
    logic [SPI_FRAME_W-1:0] rx_data_reg, rx_data_next;
    logic                   rdy_reg, rdy_next;
    logic                   sample_reg, sample_next;
    logic                   seen_rise_reg, seen_rise_next;

    // Select and clock idle high, so their synchronizers reset to 1.
    spi_edge_sync #(.RST_VAL(1'b1)) u_ss_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus.SS_n),
        .level    (ss_level),
        .rise     (ss_rise),
        .fall     (ss_fall)
    );

    spi_edge_sync #(.RST_VAL(1'b1)) u_sclk_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus.SCLK),
        .level    (sclk_level),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    // MOSI needs only the two-flop guard; its delay matches the SCLK edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_ff1_reg <= 1'b0;
            mosi_ff2_reg <= 1'b0;
        end else begin
            mosi_ff1_reg <= bus.MOSI;
            mosi_ff2_reg <= mosi_ff1_reg;
        end
    end

    // Next-state logic: frame start/end, bit sampling and shifting, rdy handling.
    always_comb begin
        state_next     = state_reg;
        shft_next      = shft_reg;
        rx_data_next   = rx_data_reg;
        rdy_next       = rdy_reg;
        sample_next    = sample_reg;
        seen_rise_next = seen_rise_reg;

        // Clears first so that a frame end later in this block overrides them.
        if (clr_rdy) begin
            rdy_next = 1'b0;
        end
        if (ss_fall) begin
            rdy_next       = 1'b0;
            seen_rise_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (wrt) begin
                    shft_next = tx_data;
                end
                if (ss_fall) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ss_rise) begin
                    // The last sampled bit has no trailing SCLK fall; push it here.
                    state_next   = ST_IDLE;
                    shft_next    = shift_in(shft_reg, sample_reg);
                    rx_data_next = shift_in(shft_reg, sample_reg);
                    rdy_next     = 1'b1;
                end else if (sclk_rise) begin
                    sample_next    = mosi_ff2_reg;
                    seen_rise_next = 1'b1;
                end else if (sclk_fall && seen_rise_reg) begin
                    // The leading fall after select has no sample yet and is skipped.
                    shft_next = shift_in(shft_reg, sample_reg);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            shft_reg      <= '0;
            rx_data_reg   <= '0;
            rdy_reg       <= 1'b0;
            sample_reg    <= 1'b0;
            seen_rise_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shft_reg      <= shft_next;
            rx_data_reg   <= rx_data_next;
            rdy_reg       <= rdy_next;
            sample_reg    <= sample_next;
            seen_rise_reg <= seen_rise_next;
        end
    end

    assign rx_data = rx_data_reg;
    assign rdy     = rdy_reg;

`ifdef SPI_SERF_MISO_TRI_EN
    assign bus.MISO = ss_level ? 1'bz : shft_reg[SPI_FRAME_W-1];
    logic unused_sync_levels;
    assign unused_sync_levels = sclk_level;
`else
    assign bus.MISO = shft_reg[SPI_FRAME_W-1];
    logic unused_sync_levels;
    assign unused_sync_levels = &{1'b0, ss_level, sclk_level};
`endif

endmodule
